// File: rtl/output_frame_packer.sv
// rtl/output_frame_packer.sv - packs gate-signal bits and 64-bit source values into a checksummed 32-bit frame
module output_frame_packer #(
  parameter int N_SIG   = 16,
  parameter int N_SRC   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exchange_data_sig,
  input  logic        sig_valid,
  input  logic        sig_bit,
  input  logic        src_valid,
  input  logic [63:0] src_data,
  input  logic        clear_err,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  output logic        timeout_err
);
  localparam int SW   = (N_SIG + 31) / 32;
  localparam int FLEN = 1 + SW + 2 * N_SRC + 1;
  localparam int AW   = $clog2(FLEN);
  localparam int SBW  = SW * 32;
  localparam int SCW  = $clog2(N_SIG + 1) + 5;
  localparam int CCW  = $clog2(N_SRC + 1) + 1;
  localparam int TW   = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SEND} state_t;
  state_t r_state, w_next;

  logic [31:0]    r_mem [FLEN];
  logic [SBW-1:0] r_sig;
  logic [SCW-1:0] r_sig_cnt;
  logic [CCW-1:0] r_src_cnt;
  logic [TW-1:0]  r_tmr;
  logic [AW-1:0]  r_rd_ptr;
  logic [31:0]    r_csum;
  logic [15:0]    r_frame_cnt;
  logic           r_overrun;
  logic           r_timeout_err;

  logic           w_start, w_sig_acc, w_src_acc, w_done, w_tmo, w_hs, w_last_hs;
  logic [AW-1:0]  w_src_hidx, w_src_lidx;
  logic [31:0]    w_header, w_sig_word, w_csum_sig, w_csum_src;

  assign w_start    = (r_state == S_IDLE) && exchange_data_sig;
  assign w_sig_acc  = (r_state == S_COLLECT) && sig_valid && (r_sig_cnt < SCW'(N_SIG));
  assign w_src_acc  = (r_state == S_COLLECT) && src_valid && (r_src_cnt < CCW'(N_SRC));
  assign w_done     = (r_sig_cnt == SCW'(N_SIG)) && (r_src_cnt == CCW'(N_SRC));
  assign w_tmo      = (r_tmr == TW'(TIMEOUT - 1));
  assign w_hs       = (r_state == S_SEND) && tx_ready;
  assign w_last_hs  = w_hs && (r_rd_ptr == AW'(FLEN - 1));
  assign w_header   = {16'hA5A5, r_frame_cnt};
  assign w_src_hidx = AW'(1 + SW + 2 * int'(r_src_cnt));
  assign w_src_lidx = AW'(2 + SW + 2 * int'(r_src_cnt));
  assign w_csum_sig = w_sig_acc ? (32'(sig_bit) << r_sig_cnt[4:0]) : 32'd0;
  assign w_csum_src = w_src_acc ? (src_data[63:32] ^ src_data[31:0]) : 32'd0;
  assign w_sig_word = 32'(r_sig >> (32 * (int'(r_rd_ptr) - 1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Completion wins over a timeout landing in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (exchange_data_sig) w_next = S_COLLECT;
      S_COLLECT: if (w_done) w_next = S_SEND;
                 else if (w_tmo) w_next = S_IDLE;
      S_SEND:    if (w_last_hs) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sig         <= '0;
      r_sig_cnt     <= '0;
      r_src_cnt     <= '0;
      r_tmr         <= '0;
      r_rd_ptr      <= '0;
      r_csum        <= '0;
      r_frame_cnt   <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_sig     <= '0;
        r_sig_cnt <= '0;
        r_src_cnt <= '0;
        r_tmr     <= '0;
        r_rd_ptr  <= '0;
        r_csum    <= w_header;
      end else if (r_state == S_COLLECT) begin
        r_tmr  <= r_tmr + 1'b1;
        r_csum <= r_csum ^ w_csum_sig ^ w_csum_src;
        if (w_sig_acc) begin
          r_sig     <= r_sig | (SBW'(sig_bit) << r_sig_cnt);
          r_sig_cnt <= r_sig_cnt + 1'b1;
        end
        if (w_src_acc) r_src_cnt <= r_src_cnt + 1'b1;
      end
      if (w_hs) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_last_hs) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (exchange_data_sig && (r_state != S_IDLE)) r_overrun <= 1'b1;
      else if (clear_err)                            r_overrun <= 1'b0;
      if ((r_state == S_COLLECT) && !w_done && w_tmo) r_timeout_err <= 1'b1;
      else if (clear_err)                              r_timeout_err <= 1'b0;
    end
  end

  // Signal words live in r_sig; the buffer holds header, source words and checksum.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_mem[0] <= w_header;
    end else if (r_state == S_COLLECT) begin
      if (w_src_acc) begin
        r_mem[w_src_hidx] <= src_data[63:32];
        r_mem[w_src_lidx] <= src_data[31:0];
      end
      if (w_done) r_mem[AW'(FLEN - 1)] <= r_csum;
    end
  end

  always_comb begin
    tx_data = '0;
    if (r_state == S_SEND) begin
      if ((r_rd_ptr >= AW'(1)) && (r_rd_ptr <= AW'(SW))) tx_data = w_sig_word;
      else                                               tx_data = r_mem[r_rd_ptr];
    end
  end

  assign tx_valid    = (r_state == S_SEND);
  assign tx_last     = tx_valid && (r_rd_ptr == AW'(FLEN - 1));
  assign busy        = (r_state != S_IDLE);
  assign frame_cnt   = r_frame_cnt;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;
endmodule

// File: tb/tb_output_frame_packer.sv
// tb/tb_output_frame_packer.sv - self-checking bench for output_frame_packer
module tb_output_frame_packer;
  localparam int N_SIG   = 16;
  localparam int N_SRC   = 8;
  localparam int TIMEOUT = 1023;
  localparam int SW      = (N_SIG + 31) / 32;
  localparam int FLEN    = 1 + SW + 2 * N_SRC + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exchange_data_sig = 1'b0;
  logic        sig_valid = 1'b0;
  logic        sig_bit = 1'b0;
  logic        src_valid = 1'b0;
  logic [63:0] src_data = '0;
  logic        clear_err = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] tx_data;
  logic        tx_valid, tx_last, busy, overrun, timeout_err;
  logic [15:0] frame_cnt;

  output_frame_packer #(.N_SIG(N_SIG), .N_SRC(N_SRC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .exchange_data_sig(exchange_data_sig),
    .sig_valid(sig_valid), .sig_bit(sig_bit), .src_valid(src_valid), .src_data(src_data),
    .clear_err(clear_err), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .busy(busy), .frame_cnt(frame_cnt), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] sig_pat = 16'hF00F;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] src_val(input int i);
    return {32'(i), 32'(i) << 4};
  endfunction

  // Reference frame, built straight from the packing rules.
  logic [31:0] exp_w [FLEN];
  task automatic build_frame(input logic [15:0] fc);
    logic [31:0] cs;
    logic [63:0] v;
    for (int w = 0; w < FLEN; w++) exp_w[w] = 32'd0;
    exp_w[0] = {16'hA5A5, fc};
    for (int k = 0; k < N_SIG; k++) exp_w[1 + k / 32][k % 32] = sig_pat[k];
    for (int j = 0; j < N_SRC; j++) begin
      v = src_val(j);
      exp_w[1 + SW + 2 * j] = v[63:32];
      exp_w[2 + SW + 2 * j] = v[31:0];
    end
    cs = 32'd0;
    for (int w = 0; w < FLEN - 1; w++) cs ^= exp_w[w];
    exp_w[FLEN - 1] = cs;
  endtask

  int          arm_gen = 0;
  int          arm_seen = 0;
  bit          active = 0;
  int          idx = 0;
  logic [15:0] m_fcnt = '0;
  int          frames_done = 0;
  int          valid_cycles = 0;
  int          busy_cycles = 0;
  int          last_cnt = 0;
  bit          hold_pending = 0;
  logic [31:0] hold_data = '0;
  logic [31:0] first_word = '0;

  always @(negedge clk) begin
    if (!rst) begin
      active = 0;
      idx = 0;
      m_fcnt = '0;
      hold_pending = 0;
    end else begin
      if (arm_gen != arm_seen) begin
        arm_seen = arm_gen;
        build_frame(m_fcnt);
        active = 1;
        idx = 0;
      end
      check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
      if (busy) busy_cycles++;
      if (tx_valid) begin
        valid_cycles++;
        if (hold_pending) check("hold_stable", tx_data, hold_data);
        if (!active) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_valid: got tx_valid=1 data %08h expected tx_valid=0", tx_data);
        end else begin
          check("tx_data", tx_data, exp_w[idx]);
          check("tx_last", 32'(tx_last), 32'(idx == FLEN - 1));
          if (idx == 0) first_word = tx_data;
          if (tx_ready) begin
            if (tx_last) last_cnt++;
            idx++;
            if (idx == FLEN) begin
              active = 0;
              frames_done++;
              m_fcnt++;
            end
          end
        end
        hold_pending = !tx_ready;
        hold_data = tx_data;
      end else begin
        check("tx_last_idle", 32'(tx_last), 32'd0);
        hold_pending = 0;
      end
    end
  end

  bit ready_mode = 0;
  bit ready_lvl = 0;
  int bp_i = 0;
  always @(posedge clk) begin
    #1;
    if (ready_mode) begin
      tx_ready = ((bp_i % 4) == 0) || ((bp_i % 4) == 3);
      bp_i++;
    end else begin
      tx_ready = ready_lvl;
    end
  end

  task automatic start_frame(input int nsig, input int nsrc, input int extra, input bit arm);
    int n;
    n = ((nsig > nsrc) ? nsig : nsrc) + extra;
    @(posedge clk); #1;
    exchange_data_sig = 1'b1;
    if (arm) arm_gen++;
    @(posedge clk); #1;
    exchange_data_sig = 1'b0;
    for (int c = 0; c < n; c++) begin
      sig_valid = (c < nsig + extra);
      sig_bit   = (c < nsig) ? sig_pat[c] : 1'b1;
      src_valid = (c < nsrc + extra);
      src_data  = (c < nsrc) ? src_val(c) : 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clk); #1;
    end
    sig_valid = 1'b0;
    src_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame_done_in_time", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
  endtask

  initial begin
    int fd, vb, bb, n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    rst = 1'b1;
    ready_lvl = 1;

    // Basic frame, with surplus inputs after completion that must be ignored.
    start_frame(N_SIG, N_SRC, 2, 1);
    check("model_w0", exp_w[0], 32'hA5A50000);
    check("model_w1", exp_w[1], 32'h0000F00F);
    check("model_w2", exp_w[2], 32'h00000000);
    check("model_w4", exp_w[4], 32'h00000001);
    check("model_w5", exp_w[5], 32'h00000010);
    check("model_csum", exp_w[FLEN - 1], 32'hA5A5F00F);
    wait_frames(1);
    check("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("f1_last_cnt", 32'(last_cnt), 32'd1);
    check("f1_header", first_word, 32'hA5A50000);

    // Backpressure 1,0,0,1.
    ready_mode = 1;
    start_frame(N_SIG, N_SRC, 0, 1);
    wait_frames(2);
    ready_mode = 0;
    check("f2_frame_cnt", 32'(frame_cnt), 32'd2);
    check("f2_header", first_word, 32'hA5A50001);

    // Overrun during SEND, clear/set collision, and pulse on the last handshake.
    ready_lvl = 0;
    start_frame(N_SIG, N_SRC, 0, 1);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("f3_in_send", 32'(tx_valid), 32'd1);
    exchange_data_sig = 1'b1;
    @(posedge clk); #1;
    exchange_data_sig = 1'b0;
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_still_send", 32'(tx_valid), 32'd1);
    pulse_clear();
    check("ovr_cleared", 32'(overrun), 32'd0);
    exchange_data_sig = 1'b1;
    clear_err = 1'b1;
    @(posedge clk); #1;
    exchange_data_sig = 1'b0;
    clear_err = 1'b0;
    check("ovr_set_wins", 32'(overrun), 32'd1);
    pulse_clear();
    check("ovr_cleared2", 32'(overrun), 32'd0);
    ready_lvl = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_last && tx_ready) && n < 100);
    #1;
    exchange_data_sig = 1'b1;
    @(posedge clk); #1;
    exchange_data_sig = 1'b0;
    check("ovr_last_hs", 32'(overrun), 32'd1);
    check("idle_after_f3", 32'(busy), 32'd0);
    check("f3_frame_cnt", 32'(frame_cnt), 32'd3);

    start_frame(N_SIG, N_SRC, 0, 1);
    wait_frames(4);
    check("f4_header", first_word, 32'hA5A50003);
    check("f4_frame_cnt", 32'(frame_cnt), 32'd4);

    // Timeout with only 5 source values.
    pulse_clear();
    check("ovr_clear3", 32'(overrun), 32'd0);
    vb = valid_cycles;
    bb = busy_cycles;
    start_frame(N_SIG, 5, 0, 0);
    n = 0;
    while (busy && n < 1200) begin
      @(posedge clk); #1;
      n++;
    end
    check("tmo_err", 32'(timeout_err), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_frame_cnt", 32'(frame_cnt), 32'd4);
    check("tmo_no_valid", 32'(valid_cycles - vb), 32'd0);
    check("tmo_collect_cycles", 32'(busy_cycles - bb), 32'd1023);
    pulse_clear();
    check("tmo_cleared", 32'(timeout_err), 32'd0);

    // Reset at the 10th word.
    fd = frames_done;
    start_frame(N_SIG, N_SRC, 0, 1);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (idx != 10 && n < 200);
    check("reached_word10", 32'(idx), 32'd10);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_tx_last", 32'(tx_last), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_tx_data", tx_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    vb = valid_cycles;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_no_valid", 32'(valid_cycles - vb), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    start_frame(N_SIG, N_SRC, 0, 1);
    wait_frames(fd + 1);
    check("f5_header", first_word, 32'hA5A50000);
    check("f5_frame_cnt", 32'(frame_cnt), 32'd1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
